// File: rtl/vscale_src_a_fwd_stage_pkg.sv
// Shared types and constants for the operand-A forwarding stage.
// The select codes mirror vscale_ctrl_constants.vh (`SRC_A_SEL_WIDTH,
// `SRC_A_RS1, `SRC_A_PC, `SRC_A_ZERO). XPR_LEN_DEF mirrors `XPR_LEN from
// rv32_opcodes.vh. Both are held here so the RTL and the bench share one
// definition without relying on include paths.
package vscale_src_a_fwd_stage_pkg;

    localparam int unsigned XPR_LEN_DEF     = 32;
    localparam int unsigned REG_AW          = 5;
    localparam int unsigned SRC_A_SEL_WIDTH = 2;

    localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_RS1  = 2'd0;
    localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_PC   = 2'd1;
    localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_ZERO = 2'd2;

    // Output register occupancy
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/vscale_byp_prio_sel.sv
// Bypass match and priority select.
// Finds the lowest-index bypass channel whose destination matches a non-zero
// rs1 while the operand select is rs1. It reports whether such a channel exists,
// whether its result is still pending, and its data.
// Ports:
//   rs1_addr   architectural rs1 index
//   rs1_sel    operand select is rs1
//   byp_valid  per-channel live register write
//   byp_pend   per-channel result not yet available
//   byp_addr   packed destination indices, channel i at [5i+4:5i]
//   byp_data   packed result data, channel i at [XPR_LEN*i +: XPR_LEN]
//   hit_c      some channel matches
//   pend_c     the winning channel is pending
//   data_c     data of the winning channel
module vscale_byp_prio_sel
    import vscale_src_a_fwd_stage_pkg::*;
#(
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned XPR_LEN = XPR_LEN_DEF
) (
    input  logic [REG_AW-1:0]          rs1_addr,
    input  logic                       rs1_sel,
    input  logic [NUM_BYP-1:0]         byp_valid,
    input  logic [NUM_BYP-1:0]         byp_pend,
    input  logic [REG_AW*NUM_BYP-1:0]  byp_addr,
    input  logic [XPR_LEN*NUM_BYP-1:0] byp_data,
    output logic                       hit_c,
    output logic                       pend_c,
    output logic [XPR_LEN-1:0]         data_c
);

    // Walk from oldest to youngest so the youngest match overwrites the rest
    always_comb begin
        hit_c  = 1'b0;
        pend_c = 1'b0;
        data_c = '0;
        for (int i = int'(NUM_BYP) - 1; i >= 0; i--) begin
            if (byp_valid[i] && rs1_sel && (rs1_addr != '0) &&
                (byp_addr[REG_AW*i +: REG_AW] == rs1_addr)) begin
                hit_c  = 1'b1;
                pend_c = byp_pend[i];
                data_c = byp_data[XPR_LEN*i +: XPR_LEN];
            end
        end
    end

endmodule

// File: rtl/vscale_src_a_fwd_stage.sv
// Registered operand-A select with bypass forwarding and load-use interlock.
// Selects rs1 / PC / zero, overrides rs1 with the youngest matching bypass
// channel, stalls while that channel is pending, and captures the result in a
// one-entry valid/ready output register.
// Build option: define VSCALE_SRC_A_FWD_EN to enable forwarding, interlock and
// the stall counter; otherwise the block is a plain registered three-way select.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready is combinational)
//   src_a_sel           operand select code
//   PC_DX, rs1_addr, rs1_data   operand sources
//   byp_valid/pend/addr/data    bypass channels, channel 0 youngest
//   out_valid/out_ready output handshake
//   alu_src_a, fwd_hit  registered operand and forward flag
//   stall_cnt           saturating interlock-cycle counter
module vscale_src_a_fwd_stage
    import vscale_src_a_fwd_stage_pkg::*;
#(
    parameter int unsigned XPR_LEN = XPR_LEN_DEF,
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SRC_A_SEL_WIDTH-1:0] src_a_sel,
    input  logic [XPR_LEN-1:0]         PC_DX,
    input  logic [REG_AW-1:0]          rs1_addr,
    input  logic [XPR_LEN-1:0]         rs1_data,
    input  logic [NUM_BYP-1:0]         byp_valid,
    input  logic [NUM_BYP-1:0]         byp_pend,
    input  logic [REG_AW*NUM_BYP-1:0]  byp_addr,
    input  logic [XPR_LEN*NUM_BYP-1:0] byp_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XPR_LEN-1:0]         alu_src_a,
    output logic                       fwd_hit,
    output logic [CNT_W-1:0]           stall_cnt
);

    out_state_e         state, state_nxt;
    logic               load;
    logic               accept;
    logic               interlock;
    logic               fwd_c;
    logic [XPR_LEN-1:0] fwd_data_c;
    logic [XPR_LEN-1:0] operand_c;

`ifdef VSCALE_SRC_A_FWD_EN
    logic byp_hit_c;
    logic byp_pend_c;

    vscale_byp_prio_sel #(
        .NUM_BYP (NUM_BYP),
        .XPR_LEN (XPR_LEN)
    ) u_byp_prio_sel (
        .rs1_addr  (rs1_addr),
        .rs1_sel   (src_a_sel == SRC_A_RS1),
        .byp_valid (byp_valid),
        .byp_pend  (byp_pend),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .hit_c     (byp_hit_c),
        .pend_c    (byp_pend_c),
        .data_c    (fwd_data_c)
    );

    // Only the winning channel's pending bit stalls
    assign interlock = byp_hit_c && byp_pend_c;
    assign fwd_c     = byp_hit_c && !byp_pend_c;
`else
    logic unused_byp;
    assign unused_byp = ^{byp_valid, byp_pend, byp_addr, byp_data};
    assign interlock  = 1'b0;
    assign fwd_c      = 1'b0;
    assign fwd_data_c = '0;
`endif

    assign out_valid = (state == S_FULL);
    assign in_ready  = (!out_valid || out_ready) && !interlock;
    assign accept    = in_valid && in_ready;

    // Operand select; undefined codes read as zero
    always_comb begin
        operand_c = '0;
        case (src_a_sel)
            SRC_A_RS1: operand_c = fwd_c ? fwd_data_c : rs1_data;
            SRC_A_PC:  operand_c = PC_DX;
            default:   operand_c = '0;
        endcase
    end

    // Output register occupancy state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load enable
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_FULL;
                    load      = 1'b1;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Operand payload register; held while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_src_a <= '0;
        end else if (load) begin
            alu_src_a <= operand_c;
        end
    end

`ifdef VSCALE_SRC_A_FWD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_hit <= 1'b0;
        end else if (load) begin
            fwd_hit <= fwd_c;
        end
    end

    // Saturating count of requested-but-interlocked cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (in_valid && interlock && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`else
    assign fwd_hit   = 1'b0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vscale_src_a_fwd_stage.sv
// Directed self-checking bench for vscale_src_a_fwd_stage.
// Expected values follow the forwarding build when VSCALE_SRC_A_FWD_EN is
// defined and the plain-select build otherwise.
module tb_vscale_src_a_fwd_stage;
    import vscale_src_a_fwd_stage_pkg::*;

    localparam int unsigned XPR_LEN = 32;
    localparam int unsigned NUM_BYP = 2;
    localparam int unsigned CNT_W   = 4;
`ifdef VSCALE_SRC_A_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic                       in_ready;
    logic [SRC_A_SEL_WIDTH-1:0] src_a_sel;
    logic [XPR_LEN-1:0]         PC_DX;
    logic [REG_AW-1:0]          rs1_addr;
    logic [XPR_LEN-1:0]         rs1_data;
    logic [NUM_BYP-1:0]         byp_valid;
    logic [NUM_BYP-1:0]         byp_pend;
    logic [REG_AW*NUM_BYP-1:0]  byp_addr;
    logic [XPR_LEN*NUM_BYP-1:0] byp_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [XPR_LEN-1:0]         alu_src_a;
    logic                       fwd_hit;
    logic [CNT_W-1:0]           stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vscale_src_a_fwd_stage #(
        .XPR_LEN (XPR_LEN),
        .NUM_BYP (NUM_BYP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a_sel (src_a_sel),
        .PC_DX     (PC_DX),
        .rs1_addr  (rs1_addr),
        .rs1_data  (rs1_data),
        .byp_valid (byp_valid),
        .byp_pend  (byp_pend),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_src_a (alu_src_a),
        .fwd_hit   (fwd_hit),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byp(input logic [1:0] v, input logic [1:0] p,
                           input logic [4:0] a1, input logic [4:0] a0,
                           input logic [31:0] d1, input logic [31:0] d0);
        byp_valid = v;
        byp_pend  = p;
        byp_addr  = {a1, a0};
        byp_data  = {d1, d0};
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        src_a_sel = SRC_A_RS1;
        PC_DX     = '0;
        rs1_addr  = '0;
        rs1_data  = '0;
        out_ready = 1'b1;
        set_byp(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_alu_src_a", alu_src_a, 32'h0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);

        // PC select
        in_valid = 1'b1; src_a_sel = SRC_A_PC; PC_DX = 32'h200;
        chk("pc_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("pc_out_valid", 32'(out_valid), 32'h1);
        chk("pc_alu", alu_src_a, 32'h200);
        chk("pc_fwd_hit", 32'(fwd_hit), 32'h0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        // Back-to-back stream, one operand per cycle
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            PC_DX = 32'(i * 16);
            tick();
            chk("stream_alu", alu_src_a, 32'(i * 16));
            chk("stream_out_valid", 32'(out_valid), 32'h1);
        end

        // Priority: both channels hit x5, channel 0 wins
        src_a_sel = SRC_A_RS1; rs1_addr = 5'd5; rs1_data = 32'h5555;
        set_byp(2'b11, 2'b00, 5'd5, 5'd5, 32'hBBBB, 32'hAAAA);
        tick();
        chk("prio_alu", alu_src_a, FWD ? 32'hAAAA : 32'h5555);
        chk("prio_fwd_hit", 32'(fwd_hit), 32'(FWD));
        // Only channel 1 matches
        set_byp(2'b11, 2'b00, 5'd5, 5'd6, 32'hBBBB, 32'hAAAA);
        tick();
        chk("ch1_alu", alu_src_a, FWD ? 32'hBBBB : 32'h5555);
        // x0 never forwards
        rs1_addr = 5'd0;
        set_byp(2'b11, 2'b00, 5'd0, 5'd0, 32'hBBBB, 32'hAAAA);
        tick();
        chk("x0_alu", alu_src_a, 32'h5555);
        chk("x0_fwd_hit", 32'(fwd_hit), 32'h0);
        // Zero and undefined select ignore a matching channel
        rs1_addr = 5'd5;
        set_byp(2'b01, 2'b00, 5'd0, 5'd5, 32'h0, 32'hAAAA);
        src_a_sel = SRC_A_ZERO;
        tick();
        chk("zero_alu", alu_src_a, 32'h0);
        chk("zero_fwd_hit", 32'(fwd_hit), 32'h0);
        src_a_sel = 2'd3;
        PC_DX = 32'hFFFF;
        tick();
        chk("undef_alu", alu_src_a, 32'h0);

        // Pending non-winner does not interlock
        src_a_sel = SRC_A_RS1;
        set_byp(2'b11, 2'b10, 5'd5, 5'd5, 32'hBBBB, 32'hC0DE);
        #1;
        chk("nonwin_pend_ready", 32'(in_ready), 32'h1);
        tick();
        chk("nonwin_pend_alu", alu_src_a, FWD ? 32'hC0DE : 32'h5555);

        // Interlock on pending winner
        in_valid = 1'b0;
        tick();
        rs1_addr = 5'd7; rs1_data = 32'h77;
        set_byp(2'b01, 2'b01, 5'd0, 5'd7, 32'h0, 32'hDEAD);
        #1;
        chk("lock_ready_no_valid", 32'(in_ready), FWD ? 32'h0 : 32'h1);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lock_in_ready", 32'(in_ready), FWD ? 32'h0 : 32'h1);
            tick();
        end
        chk("lock_stall_cnt", 32'(stall_cnt), FWD ? 32'h3 : 32'h0);
        chk("lock_out_valid", 32'(out_valid), FWD ? 32'h0 : 32'h1);
        set_byp(2'b01, 2'b00, 5'd0, 5'd7, 32'h0, 32'h1234);
        #1;
        chk("release_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("release_alu", alu_src_a, FWD ? 32'h1234 : 32'h77);
        chk("release_fwd_hit", 32'(fwd_hit), 32'(FWD));
        chk("release_stall_cnt", 32'(stall_cnt), FWD ? 32'h3 : 32'h0);
        tick();

        // Backpressure holds the captured operand
        rs1_addr = 5'd3; rs1_data = 32'h11;
        set_byp(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        in_valid = 1'b1;
        tick();
        chk("bp_capture", alu_src_a, 32'h11);
        out_ready = 1'b0; rs1_data = 32'h99;
        for (int i = 0; i < 4; i++) begin
            set_byp(2'b01, 2'b00, 5'd0, 5'd3, 32'h0, 32'(32'hCC + i));
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_hold_alu", alu_src_a, 32'h11);
            tick();
        end
        chk("bp_hold_final", alu_src_a, 32'h11);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1; rs1_data = 32'h22;
        set_byp(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_alu", alu_src_a, 32'h22);
        chk("bp_next_valid", 32'(out_valid), 32'h1);
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'h0);

        // Stall counter saturation (starts from 3)
        rs1_addr = 5'd9;
        set_byp(2'b01, 2'b01, 5'd0, 5'd9, 32'h0, 32'h9);
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("sat_mid", 32'(stall_cnt), FWD ? 32'd14 : 32'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_final", 32'(stall_cnt), FWD ? 32'd15 : 32'd0);
        in_valid = 1'b0;
        set_byp(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        tick();
        tick();

        // Reset while full drops the operand
        rs1_addr = 5'd0; rs1_data = 32'h55; in_valid = 1'b1;
        tick();
        chk("rf_capture", alu_src_a, 32'h55);
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rf_out_valid", 32'(out_valid), 32'h0);
        chk("rf_alu", alu_src_a, 32'h0);
        chk("rf_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        chk("rf_stays_empty", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
